bus_arbiter: RTL
================

Name: bus_arbiter

Overview:
- Shares the single external memory bus between the fetch port and the memory-stage load/store port of the 5-stage pipeline.
- Converts the pipeline's level-held requests into single bus transactions.
- Holds each result until the owning stage consumes it.
- Performs sub-word byte-lane steering for stores and extract/extend for loads; produces fetch_ready/mem_ready for hazard control.

Parameters:
- ADDR_W, 32, address width; must be 32 for this core.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- fetch_req  in  1  fetch stage requests the word at fetch_address.
- fetch_address  in  32  fetch address; bits [1:0] ignored.
- fetch_accept  in  1  fetch stage advanced; pulse, consumes held result.
- fetch_flush  in  1  discard current or in-flight fetch (branch/trap/mret).
- fetch_data  out  32  fetched word; valid while fetch_ready.
- fetch_ready  out  1  fetch result available.
- mem_load  in  1  load request (level).
- mem_store  in  1  store request (level).
- mem_address  in  32  byte address.
- mem_size  in  2  0 byte, 1 half, 2 word.
- mem_signed  in  1  sign-extend loads.
- mem_store_data  in  32  store data, right-aligned.
- mem_accept  in  1  memory stage advanced; pulse.
- mem_load_data  out  32  extended load result; valid while mem_ready.
- mem_ready  out  1  load/store completed and held.
- ext_valid  out  1  bus request.
- ext_write  out  1  1 store, 0 read.
- ext_address  out  32  word-aligned address ([1:0]=0).
- ext_write_data  out  32  lane-steered store data.
- ext_write_strobe  out  4  byte enables; 0 for reads.
- ext_ready  in  1  transaction completes at this edge.
- ext_read_data  in  32  read word; valid with ext_ready.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE; all outputs 0; fetch_done, mem_done and flush_pending cleared. Reset asserted mid-transaction drops ext_valid immediately; the bus tolerates abandoned requests.
- FSM states: IDLE, FETCH, MEM. All ext_* outputs are registered.
- IDLE, priority order:
  1. mem_req = mem_load|mem_store, and !mem_done → MEM.
  2. Else fetch_req && !fetch_done && !fetch_flush → FETCH.
  3. Else stay IDLE.
  - Memory always wins: it is the older instruction.
- On entering a state: latch address/size/signed/data; drive ext_valid=1 with stable ext_* until ext_ready sampled high.
- FETCH with ext_ready=1:
  - If flush_pending or fetch_flush: discard, fetch_done stays 0.
  - Else fetch_data<=ext_read_data, fetch_done<=1.
  - Next state IDLE.
- MEM with ext_ready=1:
  - Loads: mem_load_data<=extracted value, mem_done<=1.
  - Stores: mem_done<=1 only; mem_load_data unchanged.
  - Next state IDLE.
- fetch_ready=fetch_done; mem_ready=mem_done (registered).
- Latency: request seen at edge N → ext_valid from N+1. With ext_ready at N+1, ready is visible from N+2. One IDLE cycle between transactions.
- Hold rule: a done flag stays set, with data stable, until the matching accept pulse; that edge clears it. This guarantees a store is never issued twice while other stages stall. Accept while done=0 is ignored.
- fetch_flush:
  - Clears fetch_done at the edge.
  - While in FETCH, sets flush_pending, cleared on completion.
  - A new fetch is not issued in the same cycle as flush.
- Simultaneous accept and new request: done clears at the edge; the new request arbitrates in the following IDLE cycle.
- Store lanes:
  - byte: data[7:0] replicated ×4, strobe = 1<<addr[1:0].
  - half: data[15:0] replicated ×2, strobe = 0011<<{addr[1],0}.
  - word: strobe 1111.
- Load extract:
  - byte: lane addr[1:0].
  - half: lane addr[1].
  - Zero- or sign-extend per mem_signed.
- Misaligned accesses: the requester's responsibility; low address bits beyond the size's alignment are ignored.
- mem_size=3 is treated as word.

Optional Feature:
- BUS_ARBITER_FETCH_BUFFER_EN defined: single-entry buffer holding {valid, word tag, data}.
  - Filled on each completed, non-discarded fetch.
  - In IDLE, fetch_req with a tag hit and no mem request sets fetch_done and fetch_data from the buffer at that edge, with no bus transaction: ready visible 1 cycle after request.
  - Invalidated by any completed store whose word address equals the tag.
- Undefined: no buffer; every fetch uses the bus.

Decomposition:
- Shared package: size encodings (SIZE_BYTE=0, SIZE_HALF=1, SIZE_WORD=2) and the state enum {IDLE, FETCH, MEM}.
- Sub-module bus_lane_align: combinational store steering/strobe and load extract/extend. Instantiated once; unit-testable alone.

Test Plan:
- fetch_req, fetch_address=0x100, ext_ready one cycle after ext_valid, ext_read_data=0x00500093 → ext_address=0x100, ext_write=0, fetch_ready=1 two cycles after request, held until fetch_accept.
- fetch_req and mem_load same cycle, mem_address=0x2000 → MEM transaction first, then fetch 0x100; mem_ready precedes fetch_ready.
- Byte store 0xAB at 0x2003, mem_accept withheld 5 cycles → exactly one transaction: strobe=1000, ext_write_data=0xABABABAB; no reissue.
- Signed half load at 0x2002, ext_read_data=0x80001234 → mem_load_data=0xFFFF8000. Unsigned → 0x00008000.
- fetch_flush during FETCH, ext_ready 3 cycles later → fetch_ready stays 0. Next fetch_req at 0x200 issues a new transaction.
- With BUS_ARBITER_FETCH_BUFFER_EN: fetch 0x100, accept, re-request 0x100 → ready in 1 cycle, ext_valid stays 0. Store word to 0x100 then fetch 0x100 → bus transaction occurs.

Source files
------------

// File: rtl/bus_arbiter_pkg.sv
// Shared encodings for bus_arbiter: access sizes, arbiter states, word-tag helper.
package bus_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'd0;
   localparam logic [1:0] SIZE_HALF = 2'd1;
   localparam logic [1:0] SIZE_WORD = 2'd2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      MEM   = 2'd2
   } state_t;

   function automatic logic [29:0] word_tag(input logic [31:0] addr);
      return addr[31:2];
   endfunction

endpackage

// File: rtl/bus_arbiter_lane_align.sv
// bus_lane_align: combinational store byte-lane steering/strobe and load extract/extend.
module bus_lane_align
   import bus_arbiter_pkg::*;
(
   input  logic [1:0]  addr_lo,
   input  logic [1:0]  size,
   input  logic        is_signed,
   input  logic [31:0] store_data,
   input  logic [31:0] read_data,
   output logic [31:0] write_data,
   output logic [3:0]  write_strobe,
   output logic [31:0] load_value
);

   logic [7:0]  byte_s;
   logic [15:0] half_s;

   // Lane steering and extraction; size 3 falls through to word.
   always_comb begin
      write_data   = store_data;
      write_strobe = 4'b1111;
      load_value   = read_data;
      byte_s       = read_data[{addr_lo, 3'b000} +: 8];
      half_s       = addr_lo[1] ? read_data[31:16] : read_data[15:0];
      case (size)
         SIZE_BYTE: begin
            write_data   = {4{store_data[7:0]}};
            write_strobe = 4'b0001 << addr_lo;
            load_value   = {{24{is_signed & byte_s[7]}}, byte_s};
         end
         SIZE_HALF: begin
            write_data   = {2{store_data[15:0]}};
            write_strobe = 4'b0011 << {addr_lo[1], 1'b0};
            load_value   = {{16{is_signed & half_s[15]}}, half_s};
         end
         default: begin
            write_data   = store_data;
            write_strobe = 4'b1111;
            load_value   = read_data;
         end
      endcase
   end

endmodule

// File: rtl/bus_arbiter.sv
// Arbitrates the external bus between fetch and load/store, holding results until accepted.
// Optional single-entry fetch buffer enabled by defining BUS_ARBITER_FETCH_BUFFER_EN.
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_address,
   input  logic              fetch_accept,
   input  logic              fetch_flush,
   output logic [31:0]       fetch_data,
   output logic              fetch_ready,
   input  logic              mem_load,
   input  logic              mem_store,
   input  logic [ADDR_W-1:0] mem_address,
   input  logic [1:0]        mem_size,
   input  logic              mem_signed,
   input  logic [31:0]       mem_store_data,
   input  logic              mem_accept,
   output logic [31:0]       mem_load_data,
   output logic              mem_ready,
   output logic              ext_valid,
   output logic              ext_write,
   output logic [ADDR_W-1:0] ext_address,
   output logic [31:0]       ext_write_data,
   output logic [3:0]        ext_write_strobe,
   input  logic              ext_ready,
   input  logic [31:0]       ext_read_data
);

   state_t            state_r, next_state_s;
   logic              fetch_done_r, mem_done_r, flush_pending_r;
   logic [31:0]       fetch_data_r, mem_load_data_r;
   logic              ext_valid_r, ext_write_r;
   logic [ADDR_W-1:0] ext_address_r;
   logic [31:0]       ext_write_data_r;
   logic [3:0]        ext_write_strobe_r;
   logic [1:0]        lat_lo_r, lat_size_r;
   logic              lat_signed_r;
   logic [1:0]        sel_lo_s, sel_size_s;
   logic [31:0]       lane_wdata_s, lane_load_s;
   logic [3:0]        lane_strobe_s;
   logic              mem_req_s, mem_go_s, fetch_go_s, buf_take_s, fetch_fill_s;
   logic [31:0]       buf_data_s;
   logic              unused_s;

   assign unused_s     = ^fetch_address[1:0];
   assign mem_req_s    = mem_load | mem_store;
   assign mem_go_s     = mem_req_s & ~mem_done_r;
   assign fetch_go_s   = fetch_req & ~fetch_done_r & ~fetch_flush & ~buf_take_s;
   assign fetch_fill_s = (state_r == FETCH) & ext_ready & ~flush_pending_r & ~fetch_flush;

   // In IDLE the aligner sees the live request; afterwards the latched one.
   assign sel_lo_s   = (state_r == IDLE) ? mem_address[1:0] : lat_lo_r;
   assign sel_size_s = (state_r == IDLE) ? mem_size : lat_size_r;

   bus_lane_align u_lane_align (
      .addr_lo      (sel_lo_s),
      .size         (sel_size_s),
      .is_signed    (lat_signed_r),
      .store_data   (mem_store_data),
      .read_data    (ext_read_data),
      .write_data   (lane_wdata_s),
      .write_strobe (lane_strobe_s),
      .load_value   (lane_load_s)
   );

`ifdef BUS_ARBITER_FETCH_BUFFER_EN
   logic        buf_valid_r;
   logic [29:0] buf_tag_r;
   logic [31:0] buf_data_r;

   assign buf_data_s = buf_data_r;
   assign buf_take_s = (state_r == IDLE) & fetch_req & ~fetch_done_r & ~fetch_flush & ~mem_req_s
                     & buf_valid_r & (buf_tag_r == word_tag(fetch_address));

   // Fetch buffer: fill on kept fetches, drop on a store to the same word.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         buf_valid_r <= 1'b0;
         buf_tag_r   <= 30'd0;
         buf_data_r  <= 32'd0;
      end else if (fetch_fill_s) begin
         buf_valid_r <= 1'b1;
         buf_tag_r   <= word_tag(ext_address_r);
         buf_data_r  <= ext_read_data;
      end else if ((state_r == MEM) && ext_ready && ext_write_r &&
                   (word_tag(ext_address_r) == buf_tag_r)) begin
         buf_valid_r <= 1'b0;
      end
   end
`else
   assign buf_data_s = 32'd0;
   assign buf_take_s = 1'b0;
`endif

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_r <= IDLE;
      else        state_r <= next_state_s;
   end

   // Next-state arbitration: memory stage is older and always wins.
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         IDLE: begin
            if (mem_go_s)        next_state_s = MEM;
            else if (fetch_go_s) next_state_s = FETCH;
            else                 next_state_s = IDLE;
         end
         FETCH:   next_state_s = ext_ready ? IDLE : FETCH;
         MEM:     next_state_s = ext_ready ? IDLE : MEM;
         default: next_state_s = IDLE;
      endcase
   end

   // Bus drive, result capture and done-flag handshakes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_done_r       <= 1'b0;
         mem_done_r         <= 1'b0;
         flush_pending_r    <= 1'b0;
         fetch_data_r       <= 32'd0;
         mem_load_data_r    <= 32'd0;
         ext_valid_r        <= 1'b0;
         ext_write_r        <= 1'b0;
         ext_address_r      <= '0;
         ext_write_data_r   <= 32'd0;
         ext_write_strobe_r <= 4'd0;
         lat_lo_r           <= 2'd0;
         lat_size_r         <= 2'd0;
         lat_signed_r       <= 1'b0;
      end else begin
         if (mem_accept && mem_done_r) mem_done_r <= 1'b0;
         if (fetch_flush)                       fetch_done_r <= 1'b0;
         else if (fetch_accept && fetch_done_r) fetch_done_r <= 1'b0;
         case (state_r)
            IDLE: begin
               if (mem_go_s) begin
                  ext_valid_r        <= 1'b1;
                  ext_write_r        <= mem_store;
                  ext_address_r      <= {mem_address[ADDR_W-1:2], 2'b00};
                  ext_write_data_r   <= mem_store ? lane_wdata_s : 32'd0;
                  ext_write_strobe_r <= mem_store ? lane_strobe_s : 4'd0;
                  lat_lo_r           <= mem_address[1:0];
                  lat_size_r         <= mem_size;
                  lat_signed_r       <= mem_signed;
               end else if (fetch_go_s) begin
                  ext_valid_r        <= 1'b1;
                  ext_write_r        <= 1'b0;
                  ext_address_r      <= {fetch_address[ADDR_W-1:2], 2'b00};
                  ext_write_data_r   <= 32'd0;
                  ext_write_strobe_r <= 4'd0;
               end else if (buf_take_s) begin
                  fetch_done_r <= 1'b1;
                  fetch_data_r <= buf_data_s;
               end
            end
            FETCH: begin
               if (ext_ready) begin
                  ext_valid_r     <= 1'b0;
                  flush_pending_r <= 1'b0;
                  if (fetch_fill_s) begin
                     fetch_data_r <= ext_read_data;
                     fetch_done_r <= 1'b1;
                  end
               end else if (fetch_flush) begin
                  flush_pending_r <= 1'b1;
               end
            end
            MEM: begin
               if (ext_ready) begin
                  ext_valid_r <= 1'b0;
                  mem_done_r  <= 1'b1;
                  if (!ext_write_r) mem_load_data_r <= lane_load_s;
               end
            end
            default: ext_valid_r <= 1'b0;
         endcase
      end
   end

   assign fetch_data       = fetch_data_r;
   assign fetch_ready      = fetch_done_r;
   assign mem_load_data    = mem_load_data_r;
   assign mem_ready        = mem_done_r;
   assign ext_valid        = ext_valid_r;
   assign ext_write        = ext_write_r;
   assign ext_address      = ext_address_r;
   assign ext_write_data   = ext_write_data_r;
   assign ext_write_strobe = ext_write_strobe_r;

endmodule
